// File: rtl/rob_pkg.sv
// Shared types for the reorder buffer.
// Entry layout used by dispatch, execute and PRF sides.
package rob_pkg;
  localparam int PREG_W = 4;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [PREG_W-1:0] pdst;
    logic [PREG_W-1:0] old_pdst;
    logic [DATA_W-1:0] value;
  } rob_entry_t;
endpackage

// File: rtl/rob_ptr.sv
// Wrapping pointer for ROB head/tail.
// Power-of-two depth, so wrap is natural overflow.
module rob_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);
  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr)
      ptr_d = '0;
    else if (inc)
      ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr_q <= '0;
    else
      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/rob_commit.sv
// In-order reorder buffer feeding the PRF writeback port.
// Retires one completed head entry per cycle.
module rob_commit
  import rob_pkg::*;
#(
  parameter int ROB_SIZE = 8,
  parameter int TAG_W    = $clog2(ROB_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [PREG_W-1:0] alloc_pdst,
  input  logic [PREG_W-1:0] alloc_old_pdst,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cmpl_valid,
  input  logic [TAG_W-1:0]  cmpl_tag,
  input  logic [DATA_W-1:0] cmpl_val,
  output logic              wb_ena,
  output logic [PREG_W-1:0] wb_id,
  output logic [DATA_W-1:0] wb_val,
  output logic [PREG_W-1:0] old_wb,
  output logic [TAG_W:0]    count,
  output logic              empty,
  output logic              full
);
  rob_entry_t        ent_q [ROB_SIZE];
  rob_entry_t        ent_d [ROB_SIZE];
  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W:0]    count_q, count_d;
  logic              wb_ena_q, wb_ena_d;
  logic [PREG_W-1:0] wb_id_q, wb_id_d;
  logic [PREG_W-1:0] old_wb_q, old_wb_d;
  logic [DATA_W-1:0] wb_val_q, wb_val_d;
  logic              alloc_fire;
  logic              commit;
  rob_entry_t        he;

  assign full        = (count_q == (TAG_W+1)'(ROB_SIZE));
  assign empty       = (count_q == '0);
  assign alloc_ready = !full && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail;
  assign he          = ent_q[head];
  assign commit      = he.valid && he.done && !flush;

  rob_ptr #(.W(TAG_W)) u_head (
    .clk (clk),
    .rst (rst),
    .inc (commit),
    .clr (flush),
    .ptr (head)
  );

  rob_ptr #(.W(TAG_W)) u_tail (
    .clk (clk),
    .rst (rst),
    .inc (alloc_fire),
    .clr (flush),
    .ptr (tail)
  );

  always_comb begin
    ent_d    = ent_q;
    count_d  = count_q;
    wb_ena_d = 1'b0;
    wb_id_d  = wb_id_q;
    old_wb_d = old_wb_q;
    wb_val_d = wb_val_q;
    if (flush) begin
      for (int i = 0; i < ROB_SIZE; i++)
        ent_d[i] = '0;
      count_d = '0;
    end else begin
      if (cmpl_valid && ent_q[cmpl_tag].valid) begin
        ent_d[cmpl_tag].done  = 1'b1;
        ent_d[cmpl_tag].value = cmpl_val;
      end
      if (commit) begin
        ent_d[head].valid = 1'b0;
        ent_d[head].done  = 1'b0;
        wb_ena_d = 1'b1;
        wb_id_d  = he.pdst;
        old_wb_d = he.old_pdst;
        wb_val_d = he.value;
      end
      // tail==head only when empty here, so no clash with commit
      if (alloc_fire) begin
        ent_d[tail].valid    = 1'b1;
        ent_d[tail].done     = 1'b0;
        ent_d[tail].pdst     = alloc_pdst;
        ent_d[tail].old_pdst = alloc_old_pdst;
      end
      count_d = count_q
              + (TAG_W+1)'(alloc_fire)
              - (TAG_W+1)'(commit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++)
        ent_q[i] <= '0;
      count_q  <= '0;
      wb_ena_q <= 1'b0;
      wb_id_q  <= '0;
      old_wb_q <= '0;
      wb_val_q <= '0;
    end else begin
      ent_q    <= ent_d;
      count_q  <= count_d;
      wb_ena_q <= wb_ena_d;
      wb_id_q  <= wb_id_d;
      old_wb_q <= old_wb_d;
      wb_val_q <= wb_val_d;
    end
  end

  assign count  = count_q;
  assign wb_ena = wb_ena_q;
  assign wb_id  = wb_id_q;
  assign old_wb = old_wb_q;
  assign wb_val = wb_val_q;
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit.
// Expected values are hand-computed per scenario.
module tb_rob_commit;
  import rob_pkg::*;
  localparam int ROB_SIZE = 8;
  localparam int TAG_W    = 3;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              alloc_valid;
  logic [PREG_W-1:0] alloc_pdst;
  logic [PREG_W-1:0] alloc_old_pdst;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cmpl_valid;
  logic [TAG_W-1:0]  cmpl_tag;
  logic [DATA_W-1:0] cmpl_val;
  logic              wb_ena;
  logic [PREG_W-1:0] wb_id;
  logic [DATA_W-1:0] wb_val;
  logic [PREG_W-1:0] old_wb;
  logic [TAG_W:0]    count;
  logic              empty;
  logic              full;

  int n_chk  = 0;
  int n_pass = 0;

  rob_commit #(.ROB_SIZE(ROB_SIZE)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .alloc_valid    (alloc_valid),
    .alloc_pdst     (alloc_pdst),
    .alloc_old_pdst (alloc_old_pdst),
    .alloc_ready    (alloc_ready),
    .alloc_tag      (alloc_tag),
    .cmpl_valid     (cmpl_valid),
    .cmpl_tag       (cmpl_tag),
    .cmpl_val       (cmpl_val),
    .wb_ena         (wb_ena),
    .wb_id          (wb_id),
    .wb_val         (wb_val),
    .old_wb         (old_wb),
    .count          (count),
    .empty          (empty),
    .full           (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    cmpl_valid  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [3:0] p,
                       input logic [3:0] o,
                       input logic [2:0] etag);
    alloc_valid    = 1'b1;
    alloc_pdst     = p;
    alloc_old_pdst = o;
    #1;
    chk("alloc_tag", 32'(alloc_tag), 32'(etag));
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic cmpl(input logic [2:0] t,
                      input logic [7:0] v);
    cmpl_valid = 1'b1;
    cmpl_tag   = t;
    cmpl_val   = v;
    step();
    cmpl_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    alloc_pdst     = '0;
    alloc_old_pdst = '0;
    cmpl_tag       = '0;
    cmpl_val       = '0;
    idle();
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ready", 32'(alloc_ready), 1);
    chk("rst_tag", 32'(alloc_tag), 0);
    chk("rst_wb_ena", 32'(wb_ena), 0);
    chk("rst_wb_id", 32'(wb_id), 0);
    chk("rst_wb_val", 32'(wb_val), 0);
    chk("rst_old_wb", 32'(old_wb), 0);
    step();
    rst = 1'b0;

    // single alloc/complete/retire
    alloc(4'd5, 4'd2, 3'd0);
    chk("t1_count1", 32'(count), 1);
    cmpl(3'd0, 8'hA5);
    chk("t1_no_bypass", 32'(wb_ena), 0);
    step();
    chk("t1_wb_ena", 32'(wb_ena), 1);
    chk("t1_wb_id", 32'(wb_id), 5);
    chk("t1_old_wb", 32'(old_wb), 2);
    chk("t1_wb_val", 32'(wb_val), 32'hA5);
    chk("t1_count0", 32'(count), 0);
    chk("t1_empty", 32'(empty), 1);
    step();
    chk("t1_ena_drop", 32'(wb_ena), 0);
    chk("t1_id_hold", 32'(wb_id), 5);

    // out-of-order completion, in-order retire
    do_reset();
    alloc(4'd1, 4'd9, 3'd0);
    alloc(4'd2, 4'd10, 3'd1);
    alloc(4'd3, 4'd11, 3'd2);
    cmpl(3'd2, 8'h22);
    chk("t2_wait2", 32'(wb_ena), 0);
    cmpl(3'd1, 8'h11);
    chk("t2_wait1", 32'(wb_ena), 0);
    cmpl(3'd0, 8'h10);
    chk("t2_wait0", 32'(wb_ena), 0);
    step();
    chk("t2_r0_ena", 32'(wb_ena), 1);
    chk("t2_r0_id", 32'(wb_id), 1);
    chk("t2_r0_val", 32'(wb_val), 32'h10);
    step();
    chk("t2_r1_ena", 32'(wb_ena), 1);
    chk("t2_r1_id", 32'(wb_id), 2);
    chk("t2_r1_old", 32'(old_wb), 10);
    step();
    chk("t2_r2_ena", 32'(wb_ena), 1);
    chk("t2_r2_id", 32'(wb_id), 3);
    chk("t2_r2_val", 32'(wb_val), 32'h22);
    step();
    chk("t2_done", 32'(wb_ena), 0);
    chk("t2_empty", 32'(empty), 1);

    // fill, overflow attempt, commit while full
    do_reset();
    for (int i = 0; i < ROB_SIZE; i++)
      alloc(4'(i), 4'(i + 8), 3'(i));
    chk("t3_full", 32'(full), 1);
    chk("t3_ready", 32'(alloc_ready), 0);
    chk("t3_count8", 32'(count), 8);
    alloc_valid    = 1'b1;
    alloc_pdst     = 4'd15;
    alloc_old_pdst = 4'd3;
    step();
    chk("t3_ovf_count", 32'(count), 8);
    chk("t3_ovf_tag", 32'(alloc_tag), 0);
    cmpl(3'd0, 8'h5A);
    alloc_valid = 1'b1;
    chk("t3_full_rdy", 32'(alloc_ready), 0);
    step();
    chk("t4_wb_ena", 32'(wb_ena), 1);
    chk("t4_wb_id", 32'(wb_id), 0);
    chk("t4_old_wb", 32'(old_wb), 8);
    chk("t4_wb_val", 32'(wb_val), 32'h5A);
    chk("t4_count7", 32'(count), 7);
    chk("t4_ready", 32'(alloc_ready), 1);
    chk("t4_wrap_tag", 32'(alloc_tag), 0);
    step();
    alloc_valid = 1'b0;
    chk("t4_refull", 32'(full), 1);
    chk("t4_tag_after", 32'(alloc_tag), 1);
    chk("t4_ena_drop", 32'(wb_ena), 0);

    // flush beats alloc and completion
    do_reset();
    for (int i = 0; i < 4; i++)
      alloc(4'(i + 4), 4'(i), 3'(i));
    cmpl(3'd1, 8'h31);
    cmpl(3'd2, 8'h32);
    flush          = 1'b1;
    alloc_valid    = 1'b1;
    alloc_pdst     = 4'd9;
    cmpl_valid     = 1'b1;
    cmpl_tag       = 3'd0;
    cmpl_val       = 8'hFF;
    #1;
    chk("t5_rdy_flush", 32'(alloc_ready), 0);
    step();
    idle();
    chk("t5_count", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_wb_ena", 32'(wb_ena), 0);
    chk("t5_tag", 32'(alloc_tag), 0);
    cmpl(3'd0, 8'h44);
    step();
    chk("t5_stale_ena", 32'(wb_ena), 0);
    chk("t5_stale_cnt", 32'(count), 0);

    // async reset with pending entries
    do_reset();
    alloc(4'd7, 4'd1, 3'd0);
    alloc(4'd8, 4'd2, 3'd1);
    alloc(4'd9, 4'd3, 3'd2);
    cmpl(3'd0, 8'h77);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_count", 32'(count), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_tag", 32'(alloc_tag), 0);
    chk("t6_wb_ena", 32'(wb_ena), 0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("t6_no_wb", 32'(wb_ena), 0);
    chk("t6_wb_id", 32'(wb_id), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
